// File: rtl/md_phase_sequencer.sv
// MD timestep scheduler: walks the machine through INIT, SETTLE, FORCE_EVAL and
// MOTION_UPDATE for a latched iteration count, with drain detection and a per-phase abort.
module md_phase_sequencer #(
   parameter int NUM_CELLS      = 8,
   parameter int ITER_WIDTH     = 16,
   parameter int SETTLE_CYCLES  = 8,
   parameter int DRAIN_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES = 2**20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic [ITER_WIDTH-1:0] i_num_iters,
   input  logic                  i_init_done,
   input  logic [NUM_CELLS-1:0]  i_all_dirty,
   input  logic [NUM_CELLS-1:0]  i_pe_idle,
   input  logic                  i_frc_buf_empty,
   input  logic                  i_mu_done,
   output logic [1:0]            o_md_state,
   output logic                  o_pe_start,
   output logic                  o_frc_eval_done,
   output logic                  o_mu_start,
   output logic [ITER_WIDTH-1:0] o_iter_cnt,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_timeout
);
   localparam int QW = $clog2(DRAIN_CYCLES + 1);
   localparam int PW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   localparam logic [1:0] MD_IDLE = 2'd0;
   localparam logic [1:0] MD_INIT = 2'd1;
   localparam logic [1:0] MD_MU   = 2'd2;
   localparam logic [1:0] MD_FE   = 2'd3;

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_SETTLE, S_FE, S_MU, S_DONE} state_e;

   state_e                state_q;
   logic [1:0]            md_state_q;
   logic                  pe_start_q, frc_done_q, mu_start_q;
   logic                  busy_q, done_q, timeout_q;
   logic [ITER_WIDTH-1:0] iter_cnt_q, num_iters_q;
   logic [QW-1:0]         quiet_cnt_q;
   logic [PW-1:0]         phase_cnt_q;
   logic [SW-1:0]         settle_cnt_q;

   logic                  quiet;
   logic                  phase_to;
   logic [QW-1:0]         quiet_cnt_d;
   logic [PW-1:0]         phase_cnt_d;
   logic [ITER_WIDTH-1:0] iter_cnt_d;

   always_comb begin
      quiet       = (&i_all_dirty) & (&i_pe_idle) & i_frc_buf_empty;
      quiet_cnt_d = '0;
      if (quiet)
         quiet_cnt_d = (quiet_cnt_q == QW'(DRAIN_CYCLES)) ? quiet_cnt_q : quiet_cnt_q + 1'b1;
      phase_to    = (phase_cnt_q == PW'(TIMEOUT_CYCLES - 1));
      phase_cnt_d = phase_to ? phase_cnt_q : phase_cnt_q + 1'b1;
      iter_cnt_d  = (&iter_cnt_q) ? iter_cnt_q : iter_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         md_state_q   <= MD_IDLE;
         pe_start_q   <= 1'b0;
         frc_done_q   <= 1'b0;
         mu_start_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         iter_cnt_q   <= '0;
         num_iters_q  <= '0;
         quiet_cnt_q  <= '0;
         phase_cnt_q  <= '0;
         settle_cnt_q <= '0;
      end else begin
         pe_start_q <= 1'b0;
         frc_done_q <= 1'b0;
         mu_start_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  state_q     <= S_INIT;
                  md_state_q  <= MD_INIT;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  timeout_q   <= 1'b0;
                  iter_cnt_q  <= '0;
                  num_iters_q <= i_num_iters;
               end
            end
            S_INIT: begin
               if (i_init_done) begin
                  state_q      <= S_SETTLE;
                  md_state_q   <= MD_IDLE;
                  settle_cnt_q <= '0;
               end
            end
            S_SETTLE: begin
               if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                  if (iter_cnt_q == num_iters_q) begin
                     state_q    <= S_DONE;
                     md_state_q <= MD_IDLE;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                  end else begin
                     state_q     <= S_FE;
                     md_state_q  <= MD_FE;
                     pe_start_q  <= 1'b1;
                     quiet_cnt_q <= '0;
                     phase_cnt_q <= '0;
                  end
               end else begin
                  settle_cnt_q <= settle_cnt_q + 1'b1;
               end
            end
            S_FE: begin
               phase_cnt_q <= phase_cnt_d;
               // The pe_start cycle is skipped so last step's dirty flags can't count as quiet.
               if (!pe_start_q) quiet_cnt_q <= quiet_cnt_d;
               if (!pe_start_q && quiet_cnt_d == QW'(DRAIN_CYCLES)) begin
                  state_q     <= S_MU;
                  md_state_q  <= MD_MU;
                  frc_done_q  <= 1'b1;
                  mu_start_q  <= 1'b1;
                  phase_cnt_q <= '0;
               end else if (phase_to) begin
                  state_q    <= S_DONE;
                  md_state_q <= MD_IDLE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  timeout_q  <= 1'b1;
               end
            end
            S_MU: begin
               phase_cnt_q <= phase_cnt_d;
               if (!mu_start_q && i_mu_done) begin
                  state_q      <= S_SETTLE;
                  md_state_q   <= MD_IDLE;
                  iter_cnt_q   <= iter_cnt_d;
                  settle_cnt_q <= '0;
               end else if (phase_to) begin
                  state_q    <= S_DONE;
                  md_state_q <= MD_IDLE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  timeout_q  <= 1'b1;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               md_state_q <= MD_IDLE;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
            end
         endcase
      end
   end

   assign o_md_state      = md_state_q;
   assign o_pe_start      = pe_start_q;
   assign o_frc_eval_done = frc_done_q;
   assign o_mu_start      = mu_start_q;
   assign o_iter_cnt      = iter_cnt_q;
   assign o_busy          = busy_q;
   assign o_done          = done_q;
   assign o_timeout       = timeout_q;
endmodule

// File: tb/tb_md_phase_sequencer.sv
// Directed bench for md_phase_sequencer with hand-computed cycle positions.
module tb_md_phase_sequencer;
   localparam int NC = 8;
   localparam int IW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic [IW-1:0] i_num_iters = '0;
   logic          i_init_done = 1'b0;
   logic [NC-1:0] i_all_dirty = '1;
   logic [NC-1:0] i_pe_idle = '1;
   logic          i_frc_buf_empty = 1'b1;
   logic          i_mu_done = 1'b0;
   logic [1:0]    o_md_state;
   logic          o_pe_start, o_frc_eval_done, o_mu_start;
   logic [IW-1:0] o_iter_cnt;
   logic          o_busy, o_done, o_timeout;

   int vectors = 0;
   int miscompares = 0;
   int pe_cnt = 0, fe_cnt = 0, mu_cnt = 0;
   int n;

   md_phase_sequencer #(
      .NUM_CELLS(NC), .ITER_WIDTH(IW), .SETTLE_CYCLES(8),
      .DRAIN_CYCLES(16), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_iters(i_num_iters),
      .i_init_done(i_init_done), .i_all_dirty(i_all_dirty), .i_pe_idle(i_pe_idle),
      .i_frc_buf_empty(i_frc_buf_empty), .i_mu_done(i_mu_done),
      .o_md_state(o_md_state), .o_pe_start(o_pe_start), .o_frc_eval_done(o_frc_eval_done),
      .o_mu_start(o_mu_start), .o_iter_cnt(o_iter_cnt), .o_busy(o_busy),
      .o_done(o_done), .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_pe_start)      pe_cnt <= pe_cnt + 1;
      if (o_frc_eval_done) fe_cnt <= fe_cnt + 1;
      if (o_mu_start)      mu_cnt <= mu_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic cond(input int sel);
      case (sel)
         0:       return o_pe_start;
         1:       return o_frc_eval_done;
         2:       return o_mu_start;
         3:       return o_done;
         default: return (o_iter_cnt == 16'd1);
      endcase
   endfunction

   // Ticks until the selected condition holds; n = cycles waited.
   task automatic wait_until(input string tag, input int sel, input int budget, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!cond(sel) && cyc < budget);
      if (!cond(sel)) chk({tag, "_wait_expired"}, 32'd0, 32'd1);
   endtask

   task automatic start_run(input logic [IW-1:0] iters);
      i_num_iters = iters;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_state"},   {30'd0, o_md_state}, 32'd0);
      chk({tag, "_pulses"},  {29'd0, o_pe_start, o_frc_eval_done, o_mu_start}, 32'd0);
      chk({tag, "_iter"},    {16'd0, o_iter_cnt}, 32'd0);
      chk({tag, "_flags"},   {29'd0, o_busy, o_done, o_timeout}, 32'd0);
   endtask

   initial begin
      // reset state
      #12;
      chk_all_zero("reset");
      rst_n = 1'b1;
      #3;
      tick();
      chk_all_zero("post_reset");

      // N=2 with quiet inputs; init_done raised a few cycles into INIT
      i_mu_done = 1'b1;
      pe_cnt = 0; fe_cnt = 0; mu_cnt = 0;
      start_run(16'd2);
      chk("n2_init_state", {30'd0, o_md_state}, 32'd1);
      chk("n2_busy", {31'd0, o_busy}, 32'd1);
      repeat (3) tick();
      chk("n2_still_init", {30'd0, o_md_state}, 32'd1);
      i_init_done = 1'b1;
      tick();
      chk("n2_settle_state", {30'd0, o_md_state}, 32'd0);
      wait_until("n2_pe", 0, 20, n);
      chk("n2_pe_latency", n, 32'd8);
      chk("n2_fe_state", {30'd0, o_md_state}, 32'd3);
      wait_until("n2_fe", 1, 40, n);
      chk("n2_drain_latency", n, 32'd17);
      chk("n2_mu_state", {30'd0, o_md_state}, 32'd2);
      chk("n2_mu_start_with_done", {31'd0, o_mu_start}, 32'd1);
      wait_until("n2_done", 3, 200, n);
      chk("n2_pe_count", pe_cnt, 32'd2);
      chk("n2_fe_count", fe_cnt, 32'd2);
      chk("n2_mu_count", mu_cnt, 32'd2);
      chk("n2_iter", {16'd0, o_iter_cnt}, 32'd2);
      chk("n2_done_flags", {29'd0, o_busy, o_done, o_timeout}, 32'b010);

      // N=1: start pulse ignored in FORCE_EVAL; pe_idle glitch at quiet_cnt=10
      start_run(16'd1);
      wait_until("glitch_pe", 0, 20, n);
      tick();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("busy_start_ignored_state", {30'd0, o_md_state}, 32'd3);
      repeat (9) tick();
      i_pe_idle[3] = 1'b0;
      tick();
      i_pe_idle = '1;
      n = 12;
      while (!o_frc_eval_done && n < 60) begin
         tick();
         n++;
      end
      chk("glitch_drain_index", n, 32'd28);
      wait_until("glitch_done", 3, 100, n);
      chk("glitch_iter", {16'd0, o_iter_cnt}, 32'd1);

      // N=0 from DONE: straight through SETTLE, no PE start
      pe_cnt = 0;
      start_run(16'd0);
      chk("n0_init_state", {30'd0, o_md_state}, 32'd1);
      chk("n0_iter_cleared", {16'd0, o_iter_cnt}, 32'd0);
      repeat (8) tick();
      chk("n0_still_settle", {30'd0, o_busy, o_done}, 32'b10);
      tick();
      chk("n0_done", {30'd0, o_busy, o_done}, 32'b01);
      chk("n0_no_pe", pe_cnt, 32'd0);
      chk("n0_iter", {16'd0, o_iter_cnt}, 32'd0);

      // N=2: first step completes, second MU stalls and times out
      start_run(16'd2);
      wait_until("to_iter1", 4, 100, n);
      i_mu_done = 1'b0;
      wait_until("to_mu", 2, 100, n);
      repeat (63) tick();
      chk("to_not_yet", {31'd0, o_timeout}, 32'd0);
      chk("to_still_mu", {30'd0, o_md_state}, 32'd2);
      tick();
      chk("to_timeout", {31'd0, o_timeout}, 32'd1);
      chk("to_flags", {29'd0, o_busy, o_done, o_timeout}, 32'b011);
      chk("to_state", {30'd0, o_md_state}, 32'd0);
      chk("to_iter_held", {16'd0, o_iter_cnt}, 32'd1);

      // restart after abort clears timeout and count
      i_mu_done = 1'b1;
      start_run(16'd1);
      chk("restart_timeout_clr", {31'd0, o_timeout}, 32'd0);
      chk("restart_iter_clr", {16'd0, o_iter_cnt}, 32'd0);
      wait_until("restart_done", 3, 100, n);
      chk("restart_iter", {16'd0, o_iter_cnt}, 32'd1);
      chk("restart_timeout", {31'd0, o_timeout}, 32'd0);

      // async reset mid-MU, then a fresh N=1 run
      i_mu_done = 1'b0;
      start_run(16'd1);
      wait_until("rst_mu", 2, 100, n);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      #3;
      rst_n = 1'b1;
      tick();
      chk_all_zero("after_rst");
      i_mu_done = 1'b1;
      start_run(16'd1);
      wait_until("fresh_done", 3, 100, n);
      chk("fresh_iter", {16'd0, o_iter_cnt}, 32'd1);
      chk("fresh_flags", {29'd0, o_busy, o_done, o_timeout}, 32'b010);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
